tm_bank_scheduler: RTL and testbench

Write-side controller and scheduler for the two-bank (A/B) telemetry frame buffer that the TM frame reader drains. It grants a bank to the frame producer and drives its byte writes into the dual-port RAM. It pads short frames to full length and hands completed frames to the reader in commit order. It raises `Flag_A_Tx`/`Flag_B_Tx` and `pending`, and recycles banks when the reader reports `Flag_A_Tx_Finish`/`Flag_B_Tx_Finish`.

---
 rtl/tm_bank_scheduler.sv | 255 +++++++++++++++++++++++++
 tb/tb_tm_bank_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_bank_scheduler.sv
// -----------------------------------------------------------------------------
// tm_bank_scheduler
//
// Write-side controller for the two-bank (A/B) telemetry frame buffer drained
// by the TM frame reader. It grants a bank to the frame producer, forwards the
// producer's bytes into the dual-port RAM, pads short frames to FRAME_LEN with
// PAD_BYTE, and offers completed frames to the reader strictly in commit order.
// A bank is recycled when the reader signals it has finished with that bank.
//
// Ports:
//   ClkI_Dec2           clock, shared with the frame reader
//   Rst                 synchronous reset, active-high
//   Tx_Enable           downlink enable; registered onto En_Read_Buff
//   Wr_Req              producer bank request (level, held until Wr_Grant)
//   Wr_Grant            one-cycle pulse: bank assigned, filling starts
//   Wr_Bank             bank being filled (0 = A, 1 = B)
//   Wr_Valid/Wr_Data    payload byte strobe and byte
//   Wr_Commit           end-of-frame marker (may coincide with last byte)
//   Wr_Abort            discard the frame in progress
//   USER_WEN/WA/WD      RAM write port
//   Flag_A_Tx/Flag_B_Tx bank offered to the reader (at most one at a time)
//   Flag_x_Tx_Finish    reader done with bank x (level, edge-detected here)
//   pending             at least one bank holds a complete frame
//   En_Read_Buff        Tx_Enable delayed one clock
//   Overrun             sticky: byte arrived with the bank already full
//   Finish_Err          sticky: finish edge for a bank that was not offered
//   Frame_Count         frames committed, wrapping 16-bit counter
// -----------------------------------------------------------------------------
module tm_bank_scheduler #(
  parameter int         FRAME_LEN   = 223,
  parameter int         BANK_B_BASE = 512,
  parameter logic [7:0] PAD_BYTE    = 8'h55
) (
  input  logic        ClkI_Dec2,
  input  logic        Rst,
  input  logic        Tx_Enable,
  input  logic        Wr_Req,
  output logic        Wr_Grant,
  output logic        Wr_Bank,
  input  logic        Wr_Valid,
  input  logic [7:0]  Wr_Data,
  input  logic        Wr_Commit,
  input  logic        Wr_Abort,
  output logic        USER_WEN,
  output logic [9:0]  USER_WA,
  output logic [7:0]  USER_WD,
  output logic        Flag_A_Tx,
  output logic        Flag_B_Tx,
  input  logic        Flag_A_Tx_Finish,
  input  logic        Flag_B_Tx_Finish,
  output logic        pending,
  output logic        En_Read_Buff,
  output logic        Overrun,
  output logic        Finish_Err,
  output logic [15:0] Frame_Count
);

  localparam int             CW     = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0]  LEN    = CW'(FRAME_LEN);
  localparam logic [CW-1:0]  LEN_M1 = CW'(FRAME_LEN - 1);
  localparam logic [9:0]     B_BASE = 10'(BANK_B_BASE);

  typedef enum logic [1:0] {B_FREE, B_FILL, B_READY} bank_state_t;
  typedef enum logic [1:0] {W_IDLE, W_FILL, W_PAD}   wr_state_t;

  // Registered state
  wr_state_t   wr_q;
  bank_state_t bank_q [2];
  logic [CW-1:0] cnt_q;
  logic        last_q;     // bank granted most recently
  logic        oldest_q;   // READY bank committed first
  logic        fin_a_q, fin_a_qq, fin_b_q, fin_b_qq;

  // Next-state values
  wr_state_t   wr_n;
  bank_state_t bank_n [2];
  logic [CW-1:0] cnt_n, cnt_v;
  logic        cur_n, last_n, oldest_n, pick;
  logic        grant_n, wen_n, overrun_n, commit_done;
  logic [9:0]  wa_n;
  logic [7:0]  wd_n;
  logic [15:0] frame_n;

  // Finish edges: only an edge on the currently offered bank is honoured.
  logic fin_a_rise, fin_b_rise, fin_a_ok, fin_b_ok;
  logic ready_a_af, ready_b_af, free_a_af, free_b_af;
  logic flag_a_n, flag_b_n, pending_n, err_n;
  logic [9:0] base;

  assign fin_a_rise = fin_a_q & ~fin_a_qq;
  assign fin_b_rise = fin_b_q & ~fin_b_qq;
  assign fin_a_ok   = fin_a_rise & Flag_A_Tx;
  assign fin_b_ok   = fin_b_rise & Flag_B_Tx;

  // Bank status as it will be once this cycle's finish is applied; a bank
  // being released this cycle is already grantable.
  assign ready_a_af = (bank_q[0] == B_READY) && !fin_a_ok;
  assign ready_b_af = (bank_q[1] == B_READY) && !fin_b_ok;
  assign free_a_af  = (bank_q[0] == B_FREE)  || fin_a_ok;
  assign free_b_af  = (bank_q[1] == B_FREE)  || fin_b_ok;

  // Flags follow the current bank state one clock later, except that a
  // finish hands the offer straight over to the other READY bank.
  assign flag_a_n  = (bank_q[0] == B_READY) && !fin_a_ok && (!oldest_q || fin_b_ok);
  assign flag_b_n  = (bank_q[1] == B_READY) && !fin_b_ok && ( oldest_q || fin_a_ok);
  assign pending_n = ready_a_af | ready_b_af;
  assign err_n     = Finish_Err | (fin_a_rise & ~Flag_A_Tx) | (fin_b_rise & ~Flag_B_Tx);

  assign base = Wr_Bank ? B_BASE : 10'd0;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    wr_n        = wr_q;
    bank_n[0]   = bank_q[0];
    bank_n[1]   = bank_q[1];
    cnt_n       = cnt_q;
    cnt_v       = cnt_q;
    cur_n       = Wr_Bank;
    last_n      = last_q;
    oldest_n    = oldest_q;
    pick        = 1'b0;
    grant_n     = 1'b0;
    wen_n       = 1'b0;
    wa_n        = USER_WA;
    wd_n        = USER_WD;
    overrun_n   = Overrun;
    frame_n     = Frame_Count;
    commit_done = 1'b0;

    if (fin_a_ok) begin
      bank_n[0] = B_FREE;
      if (bank_q[1] == B_READY) oldest_n = 1'b1;
    end
    if (fin_b_ok) begin
      bank_n[1] = B_FREE;
      if (bank_q[0] == B_READY) oldest_n = 1'b0;
    end

    case (wr_q)
      W_IDLE: begin
        if (Wr_Req && (free_a_af || free_b_af)) begin
          // Alternate banks when both are free so neither starves.
          if (free_a_af && free_b_af) pick = ~last_q;
          else                        pick = !free_a_af;
          grant_n      = 1'b1;
          cur_n        = pick;
          last_n       = pick;
          cnt_n        = '0;
          bank_n[pick] = B_FILL;
          wr_n         = W_FILL;
        end
      end

      W_FILL: begin
        if (Wr_Abort) begin
          bank_n[Wr_Bank] = B_FREE;
          wr_n            = W_IDLE;
        end else begin
          if (Wr_Valid) begin
            if (cnt_q != LEN) begin
              wen_n = 1'b1;
              wa_n  = base + 10'(cnt_q);
              wd_n  = Wr_Data;
              cnt_v = cnt_q + 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end
          cnt_n = cnt_v;
          // A byte in the commit cycle counts before the length is judged.
          if (Wr_Commit) begin
            if (cnt_v == LEN) commit_done = 1'b1;
            else              wr_n        = W_PAD;
          end
        end
      end

      W_PAD: begin
        if (Wr_Abort) begin
          bank_n[Wr_Bank] = B_FREE;
          wr_n            = W_IDLE;
        end else begin
          wen_n = 1'b1;
          wa_n  = base + 10'(cnt_q);
          wd_n  = PAD_BYTE;
          cnt_n = cnt_q + 1'b1;
          if (cnt_q == LEN_M1) commit_done = 1'b1;
        end
      end

      default: wr_n = W_IDLE;
    endcase

    if (commit_done) begin
      bank_n[Wr_Bank] = B_READY;
      wr_n            = W_IDLE;
      frame_n         = Frame_Count + 16'd1;
      // Keep commit order: only become oldest if the other bank will not
      // be holding a frame after this cycle.
      if (!(Wr_Bank ? ready_a_af : ready_b_af)) oldest_n = Wr_Bank;
    end
  end

  always_ff @(posedge ClkI_Dec2) begin
    if (Rst) begin
      wr_q         <= W_IDLE;
      bank_q[0]    <= B_FREE;
      bank_q[1]    <= B_FREE;
      cnt_q        <= '0;
      last_q       <= 1'b1;   // first grant after reset goes to bank A
      oldest_q     <= 1'b0;
      fin_a_q      <= 1'b0;
      fin_a_qq     <= 1'b0;
      fin_b_q      <= 1'b0;
      fin_b_qq     <= 1'b0;
      Wr_Grant     <= 1'b0;
      Wr_Bank      <= 1'b0;
      USER_WEN     <= 1'b0;
      USER_WA      <= '0;
      USER_WD      <= '0;
      Flag_A_Tx    <= 1'b0;
      Flag_B_Tx    <= 1'b0;
      pending      <= 1'b0;
      En_Read_Buff <= 1'b0;
      Overrun      <= 1'b0;
      Finish_Err   <= 1'b0;
      Frame_Count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wr_q         <= wr_n;
      bank_q[0]    <= bank_n[0];
      bank_q[1]    <= bank_n[1];
      cnt_q        <= cnt_n;
      last_q       <= last_n;
      oldest_q     <= oldest_n;
      fin_a_q      <= Flag_A_Tx_Finish;
      fin_a_qq     <= fin_a_q;
      fin_b_q      <= Flag_B_Tx_Finish;
      fin_b_qq     <= fin_b_q;
      Wr_Grant     <= grant_n;
      Wr_Bank      <= cur_n;
      USER_WEN     <= wen_n;
      USER_WA      <= wa_n;
      USER_WD      <= wd_n;
      Flag_A_Tx    <= flag_a_n;
      Flag_B_Tx    <= flag_b_n;
      pending      <= pending_n;
      En_Read_Buff <= Tx_Enable;
      Overrun      <= overrun_n;
      Finish_Err   <= err_n;
      Frame_Count  <= frame_n;
    end
  end

endmodule

// File: tb/tb_tm_bank_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tm_bank_scheduler
//
// Directed bench for tm_bank_scheduler. Stimulus pushes the expected RAM
// writes and grants into queues; a monitor on the falling edge pops and
// compares whenever the DUT writes or grants. Flags and status outputs are
// checked directly at hand-computed points.
// -----------------------------------------------------------------------------
module tb_tm_bank_scheduler;

  logic        ClkI_Dec2 = 1'b0;
  logic        Rst = 1'b1;
  logic        Tx_Enable = 1'b0;
  logic        Wr_Req = 1'b0;
  logic        Wr_Grant;
  logic        Wr_Bank;
  logic        Wr_Valid = 1'b0;
  logic [7:0]  Wr_Data = 8'h00;
  logic        Wr_Commit = 1'b0;
  logic        Wr_Abort = 1'b0;
  logic        USER_WEN;
  logic [9:0]  USER_WA;
  logic [7:0]  USER_WD;
  logic        Flag_A_Tx, Flag_B_Tx;
  logic        Flag_A_Tx_Finish = 1'b0;
  logic        Flag_B_Tx_Finish = 1'b0;
  logic        pending;
  logic        En_Read_Buff;
  logic        Overrun;
  logic        Finish_Err;
  logic [15:0] Frame_Count;

  tm_bank_scheduler dut (
    .ClkI_Dec2        (ClkI_Dec2),
    .Rst              (Rst),
    .Tx_Enable        (Tx_Enable),
    .Wr_Req           (Wr_Req),
    .Wr_Grant         (Wr_Grant),
    .Wr_Bank          (Wr_Bank),
    .Wr_Valid         (Wr_Valid),
    .Wr_Data          (Wr_Data),
    .Wr_Commit        (Wr_Commit),
    .Wr_Abort         (Wr_Abort),
    .USER_WEN         (USER_WEN),
    .USER_WA          (USER_WA),
    .USER_WD          (USER_WD),
    .Flag_A_Tx        (Flag_A_Tx),
    .Flag_B_Tx        (Flag_B_Tx),
    .Flag_A_Tx_Finish (Flag_A_Tx_Finish),
    .Flag_B_Tx_Finish (Flag_B_Tx_Finish),
    .pending          (pending),
    .En_Read_Buff     (En_Read_Buff),
    .Overrun          (Overrun),
    .Finish_Err       (Finish_Err),
    .Frame_Count      (Frame_Count)
  );

  always #5 ClkI_Dec2 = ~ClkI_Dec2;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  wr_exp [$];
  logic grant_exp [$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write and every grant must match the queued expectation.
  initial begin
    wr_t  e;
    logic gb;
    forever begin
      @(negedge ClkI_Dec2);
      if (USER_WEN === 1'b1) begin
        if (wr_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", USER_WA, USER_WD);
        end else begin
          e = wr_exp.pop_front();
          check("wr_addr", 32'(USER_WA), 32'(e.addr));
          check("wr_data", 32'(USER_WD), 32'(e.data));
        end
      end
      if (Wr_Grant === 1'b1) begin
        if (grant_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: bank %0d, none expected", Wr_Bank);
        end else begin
          gb = grant_exp.pop_front();
          check("grant_bank", 32'(Wr_Bank), 32'(gb));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge ClkI_Dec2);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic push_wr(input int addr, input int data);
    wr_t e;
    e.addr = 10'(addr);
    e.data = 8'(data);
    wr_exp.push_back(e);
  endtask

  // Request a bank and wait (bounded) for the grant.
  task automatic request(input logic bank);
    int n;
    grant_exp.push_back(bank);
    Wr_Req = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (Wr_Grant !== 1'b1 && n < 20);
    check("grant_seen", 32'(Wr_Grant), 32'd1);
    Wr_Req = 1'b0;
  endtask

  // Send n bytes of val0, val0+1, ... to base, base+1, ...
  task automatic send(input int n, input int base, input int val0, input bit commit_last);
    for (int i = 0; i < n; i++) begin
      Wr_Valid  = 1'b1;
      Wr_Data   = 8'(val0 + i);
      Wr_Commit = commit_last && (i == n - 1);
      push_wr(base + i, val0 + i);
      cyc();
    end
    Wr_Valid  = 1'b0;
    Wr_Commit = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_grant",   32'(Wr_Grant),     32'd0);
    check("rst_bank",    32'(Wr_Bank),      32'd0);
    check("rst_wen",     32'(USER_WEN),     32'd0);
    check("rst_wa",      32'(USER_WA),      32'd0);
    check("rst_wd",      32'(USER_WD),      32'd0);
    check("rst_flag_a",  32'(Flag_A_Tx),    32'd0);
    check("rst_flag_b",  32'(Flag_B_Tx),    32'd0);
    check("rst_pending", 32'(pending),      32'd0);
    check("rst_en_read", 32'(En_Read_Buff), 32'd0);
    check("rst_overrun", 32'(Overrun),      32'd0);
    check("rst_fin_err", 32'(Finish_Err),   32'd0);
    check("rst_count",   32'(Frame_Count),  32'd0);
  endtask

  initial begin
    // Reset, with Tx_Enable high so En_Read_Buff is shown held low by Rst.
    Tx_Enable = 1'b1;
    wait_cycles(3);
    check_reset_values();
    Rst = 1'b0;
    cyc();
    check("en_read_buff", 32'(En_Read_Buff), 32'd1);

    // Full frame into bank A, commit on the last byte.
    request(1'b0);
    send(223, 0, 0, 1'b1);
    check("full_count_at_commit", 32'(Frame_Count), 32'd1);
    check("full_flag_a_delayed",  32'(Flag_A_Tx),   32'd0);
    cyc();
    check("full_flag_a", 32'(Flag_A_Tx), 32'd1);
    check("full_flag_b", 32'(Flag_B_Tx), 32'd0);
    check("full_pending", 32'(pending),  32'd1);

    // Short frame into bank B: 100 bytes then pad 612..734 with 0x55.
    request(1'b1);
    send(100, 512, 8'h80, 1'b0);
    for (int i = 100; i < 223; i++) push_wr(512 + i, 8'h55);
    Wr_Commit = 1'b1;
    cyc();
    Wr_Commit = 1'b0;
    wait_cycles(122);
    check("pad_count_before_last", 32'(Frame_Count), 32'd1);
    cyc();
    check("pad_count_after_last", 32'(Frame_Count), 32'd2);
    cyc();
    check("order_flag_a", 32'(Flag_A_Tx), 32'd1);
    check("order_flag_b", 32'(Flag_B_Tx), 32'd0);

    // Finish A: A released and B offered two clocks after the input rises.
    Flag_A_Tx_Finish = 1'b1;
    cyc();
    check("finA_flag_a_hold", 32'(Flag_A_Tx), 32'd1);
    cyc();
    check("finA_flag_a", 32'(Flag_A_Tx), 32'd0);
    check("finA_flag_b", 32'(Flag_B_Tx), 32'd1);
    check("finA_pending", 32'(pending), 32'd1);
    wait_cycles(2);
    Flag_A_Tx_Finish = 1'b0;

    // Refill A while B is offered: A goes READY but B keeps the offer.
    request(1'b0);
    send(223, 0, 8'h30, 1'b1);
    cyc();
    check("refill_flag_a", 32'(Flag_A_Tx), 32'd0);
    check("refill_flag_b", 32'(Flag_B_Tx), 32'd1);
    check("refill_count",  32'(Frame_Count), 32'd3);

    // Both READY: a held request waits until B's finish frees it.
    Wr_Req = 1'b1;
    wait_cycles(5);
    check("full_no_grant", 32'(Wr_Grant), 32'd0);
    Flag_B_Tx_Finish = 1'b1;
    grant_exp.push_back(1'b1);
    cyc();
    check("freed_no_grant_yet", 32'(Wr_Grant), 32'd0);
    cyc();
    check("freed_grant", 32'(Wr_Grant), 32'd1);
    check("freed_bank",  32'(Wr_Bank),  32'd1);
    check("freed_flag_b", 32'(Flag_B_Tx), 32'd0);
    check("freed_flag_a", 32'(Flag_A_Tx), 32'd1);
    Wr_Req = 1'b0;
    wait_cycles(2);
    Flag_B_Tx_Finish = 1'b0;

    // Abort after 50 bytes into B: nothing committed.
    send(50, 512, 8'h10, 1'b0);
    Wr_Abort = 1'b1;
    cyc();
    Wr_Abort = 1'b0;
    wait_cycles(2);
    check("abort_count",  32'(Frame_Count), 32'd3);
    check("abort_flag_b", 32'(Flag_B_Tx),   32'd0);
    check("abort_flag_a", 32'(Flag_A_Tx),   32'd1);

    // Overrun: 224 bytes into B; the 224th is dropped.
    request(1'b1);
    send(223, 512, 0, 1'b0);
    check("overrun_before", 32'(Overrun), 32'd0);
    Wr_Valid = 1'b1;
    Wr_Data  = 8'hEE;
    cyc();
    Wr_Valid = 1'b0;
    check("overrun_after", 32'(Overrun), 32'd1);
    Wr_Commit = 1'b1;
    cyc();
    Wr_Commit = 1'b0;
    check("overrun_count", 32'(Frame_Count), 32'd4);
    cyc();
    check("overrun_flag_a", 32'(Flag_A_Tx), 32'd1);
    check("overrun_flag_b", 32'(Flag_B_Tx), 32'd0);

    // Drain: finish A then finish B.
    Flag_A_Tx_Finish = 1'b1;
    wait_cycles(2);
    check("drain_flag_a", 32'(Flag_A_Tx), 32'd0);
    check("drain_flag_b", 32'(Flag_B_Tx), 32'd1);
    wait_cycles(2);
    Flag_A_Tx_Finish = 1'b0;
    Flag_B_Tx_Finish = 1'b1;
    wait_cycles(2);
    check("drain_b_flag",    32'(Flag_B_Tx),  32'd0);
    check("drain_pending",   32'(pending),    32'd0);
    check("drain_no_fin_err", 32'(Finish_Err), 32'd0);
    wait_cycles(2);
    Flag_B_Tx_Finish = 1'b0;
    wait_cycles(2);

    // Spurious finish on B with nothing offered.
    Flag_B_Tx_Finish = 1'b1;
    cyc();
    check("spurious_err_hold", 32'(Finish_Err), 32'd0);
    cyc();
    check("spurious_err",    32'(Finish_Err), 32'd1);
    check("spurious_flag_b", 32'(Flag_B_Tx),  32'd0);
    Flag_B_Tx_Finish = 1'b0;
    wait_cycles(2);

    // Reset in the middle of padding. Last grant was B, so A comes next.
    request(1'b0);
    send(10, 0, 8'hA0, 1'b0);
    for (int i = 10; i < 15; i++) push_wr(i, 8'h55);
    Wr_Commit = 1'b1;
    cyc();
    Wr_Commit = 1'b0;
    wait_cycles(5);
    Rst = 1'b1;
    cyc();
    check_reset_values();
    Rst = 1'b0;
    cyc();
    check("post_rst_en_read", 32'(En_Read_Buff), 32'd1);

    // After reset both banks are free again and bank A is granted first.
    request(1'b0);
    Wr_Abort = 1'b1;
    cyc();
    Wr_Abort = 1'b0;
    wait_cycles(3);

    check("wr_queue_empty",    32'(wr_exp.size()),    32'd0);
    check("grant_queue_empty", 32'(grant_exp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
